multu_hilo: RTL and testbench
=============================

MULTU_HILO -- requirements
Module: multu_hilo

Interface
REQ-001 The block SHALL expose the ports listed in REQ-002 through REQ-009: one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 dataA  input  32  unsigned multiplicand, sampled only at start.
REQ-005 dataB  input  32  unsigned multiplier, sampled only at start.
REQ-006 Signal  input  6  funct code; MULTU = 6'b011001 requests a multiply.
REQ-007 HiOut  output  32  HI register, driven continuously to the result mux.
REQ-008 LoOut  output  32  LO register, driven continuously to the result mux.
REQ-009 busy  output  1  high while a multiply is in progress; done  output  1  one-cycle pulse on the cycle HI/LO are written.

Function
REQ-010 Algorithm SHALL be unsigned shift-add: 64-bit multiplicand register shifted left one bit per cycle, 32-bit multiplier register shifted right one bit per cycle, 64-bit product accumulator adding the multiplicand when multiplier bit 0 is 1.
REQ-011 States SHALL be IDLE and RUN only.
REQ-012 IDLE->RUN on a clock edge where Signal==MULTU and armed==1: load multiplicand={32'b0,dataA}, multiplier=dataB, product=0, count=0, armed<=0.
REQ-013 armed SHALL be set to 1 on any edge where Signal!=MULTU; a MULTU held for multiple cycles starts exactly one multiply.
REQ-014 RUN: each edge performs one iteration and increments count (6-bit); the edge on which count reaches 32 SHALL write HI=product[63:32], LO=product[31:0] (including that iteration), pulse done, and return to IDLE.
REQ-015 Latency: HI/LO SHALL update on the 33rd rising edge counting the start edge as 1; busy high from the edge after start through the write edge.
REQ-016 Signal==MULTU while in RUN SHALL be ignored; dataA/dataB changes during RUN SHALL not affect the result.
REQ-017 HiOut/LoOut SHALL hold their previous values throughout RUN and change only on the write edge; MFHI/MFLO reads during RUN return the old values.
REQ-018 Multiplication SHALL be exact modulo 2^64; no overflow or flags.
REQ-019 done SHALL be low in every cycle other than the write cycle.

Reset
REQ-020 reset asserted SHALL immediately force state=IDLE, HiOut=0, LoOut=0, busy=0, done=0, count=0, product=0, armed=1.
REQ-021 Reset during RUN SHALL abort the multiply with no HI/LO write; the first start after reset deassertion follows REQ-012.

Configuration
REQ-022 Macro MULTU_EARLY_TERM_EN SHALL enable early termination.
REQ-023 With MULTU_EARLY_TERM_EN defined: in RUN, if the multiplier register after the current shift is zero, that edge SHALL write HI/LO, pulse done, and return to IDLE; dataB==0 completes on the first RUN edge; results are identical to REQ-018.
REQ-024 Without MULTU_EARLY_TERM_EN: latency SHALL always be fixed per REQ-015, regardless of operands.

Verification
REQ-025 dataA=3, dataB=5, MULTU for 1 cycle -> 33rd edge: HiOut=0, LoOut=15, done pulse for 1 cycle.
REQ-026 dataA=dataB=32'hFFFFFFFF -> HiOut=32'hFFFFFFFE, LoOut=32'h00000001.
REQ-027 MULTU held for 80 cycles with dataA=2, dataB=7 -> exactly one done pulse; LoOut=14; no restart until Signal leaves MULTU.
REQ-028 Start 12345*678, assert reset at cycle 10 of RUN -> HiOut=LoOut=0, busy=0, no done; a new start after reset produces LoOut=8369910.
REQ-029 Early-term build: dataA=9, dataB=4 -> done on 3rd RUN edge, LoOut=36; non-macro build -> same value on 33rd edge.
REQ-030 Mid-RUN, change dataA/dataB and pulse MULTU again -> result reflects the originally sampled operands; only one done.

Source files
------------

// File: rtl/multu_hilo.sv
// multu_hilo: multi-cycle unsigned 32x32 shift-add multiplier that writes the
// HI/LO register pair when it completes.
//
// Ports:
//   clk     rising-edge clock for all state
//   reset   asynchronous, active-high; clears all state
//   dataA   unsigned multiplicand, sampled only on the start edge
//   dataB   unsigned multiplier, sampled only on the start edge
//   Signal  funct code; 6'b011001 (MULTU) requests a multiply
//   HiOut   HI register (upper 32 bits of the last product)
//   LoOut   LO register (lower 32 bits of the last product)
//   busy    high while a multiply is in progress
//   done    one-cycle pulse on the cycle HI/LO are written
//
// Build option: define MULTU_EARLY_TERM_EN to finish as soon as the remaining
// multiplier bits are all zero. Without it the latency is fixed at 32 RUN edges.

module multu_hilo (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] dataA,
   input  logic [31:0] dataB,
   input  logic [5:0]  Signal,
   output logic [31:0] HiOut,
   output logic [31:0] LoOut,
   output logic        busy,
   output logic        done
);

   localparam int unsigned W  = 32;
   localparam int unsigned PW = 2 * W;
   localparam int unsigned CW = 6;
   localparam logic [5:0]    MULTU      = 6'b011001;
   localparam logic [CW-1:0] LAST_COUNT = CW'(W);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state, state_d;
   logic [PW-1:0]   mcand, mcand_d;
   logic [W-1:0]    mplier, mplier_d;
   logic [PW-1:0]   product, product_d;
   logic [CW-1:0]   count, count_d;
   logic            armed, armed_d;
   logic [W-1:0]    hi_d, lo_d;
   logic            busy_d, done_d;

   // One shift-add iteration, including the add for the current bit.
   logic [PW-1:0]   sum;
   logic [W-1:0]    mplier_sh;
   logic [CW-1:0]   count_inc;
   logic            finish;

   assign sum       = product + (mplier[0] ? mcand : PW'(0));
   assign mplier_sh = mplier >> 1;
   assign count_inc = count + CW'(1);

`ifdef MULTU_EARLY_TERM_EN
   assign finish = (count_inc == LAST_COUNT) || (mplier_sh == '0);
`else
   assign finish = (count_inc == LAST_COUNT);
`endif

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         mcand   <= '0;
         mplier  <= '0;
         product <= '0;
         count   <= '0;
         armed   <= 1'b1;
         HiOut   <= '0;
         LoOut   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_d;
         mcand   <= mcand_d;
         mplier  <= mplier_d;
         product <= product_d;
         count   <= count_d;
         armed   <= armed_d;
         HiOut   <= hi_d;
         LoOut   <= lo_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d   = state;
      mcand_d   = mcand;
      mplier_d  = mplier;
      product_d = product;
      count_d   = count;
      hi_d      = HiOut;
      lo_d      = LoOut;
      busy_d    = busy;
      done_d    = 1'b0;
      // Re-arm whenever MULTU is absent so a held MULTU starts only once.
      armed_d   = (Signal != MULTU) ? 1'b1 : armed;

      unique case (state)
         IDLE: begin
            if (Signal == MULTU && armed) begin
               mcand_d   = {{W{1'b0}}, dataA};
               mplier_d  = dataB;
               product_d = '0;
               count_d   = '0;
               armed_d   = 1'b0;
               busy_d    = 1'b1;
               state_d   = RUN;
            end
         end
         RUN: begin
            // MULTU and operand changes are ignored while running.
            product_d = sum;
            mcand_d   = mcand << 1;
            mplier_d  = mplier_sh;
            count_d   = count_inc;
            if (finish) begin
               hi_d    = sum[PW-1:W];
               lo_d    = sum[W-1:0];
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_multu_hilo.sv
// tb_multu_hilo: self-checking bench for multu_hilo. Expected products come
// from plain 64-bit arithmetic and expected latency from the multiplier's
// bit length (early-term build) or the fixed 32 RUN edges.

module tb_multu_hilo;

   localparam logic [5:0] MULTU = 6'b011001;

   logic        clk;
   logic        reset;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic [5:0]  Signal;
   logic [31:0] HiOut;
   logic [31:0] LoOut;
   logic        busy;
   logic        done;

   int total = 0;
   int bad   = 0;

   // Model of the architectural HI/LO contents.
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   multu_hilo dut (
      .clk    (clk),
      .reset  (reset),
      .dataA  (dataA),
      .dataB  (dataB),
      .Signal (Signal),
      .HiOut  (HiOut),
      .LoOut  (LoOut),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Number of RUN edges until the write edge.
   function automatic int exp_lat(input logic [31:0] b);
`ifdef MULTU_EARLY_TERM_EN
      for (int i = 31; i >= 0; i--)
         if (b[i]) return i + 1;
      return 1;
`else
      return 32;
`endif
   endfunction

   task automatic test_reset();
      reset = 1'b1; Signal = 6'd0; dataA = '0; dataB = '0;
      repeat (2) @(negedge clk);
      total++;
      if ({HiOut, LoOut, busy, done} !== 66'd0) begin
         bad++;
         $display("FAIL reset_hold: got hi=%h lo=%h busy=%b done=%b, want all zero", HiOut, LoOut, busy, done);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({HiOut, LoOut, busy, done} !== 66'd0) begin
         bad++;
         $display("FAIL reset_release: got hi=%h lo=%h busy=%b done=%b, want all zero", HiOut, LoOut, busy, done);
      end
   endtask

   // mode 0: single-cycle MULTU; 1: MULTU held; 2: mid-run operand change + MULTU pulse.
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int mode, input string tag);
      logic [63:0] full;
      int lat, edges, pulses;
      bit seen;
      full = {32'd0, a} * {32'd0, b};
      lat  = exp_lat(b);
      @(negedge clk);
      dataA = a; dataB = b; Signal = MULTU;
      @(posedge clk);
      #1;
      if (mode != 1) Signal = 6'd0;
      edges = 0; seen = 0;
      while (!seen && edges < 40) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (mode == 2 && edges == 5) begin
            dataA = $urandom; dataB = $urandom; Signal = MULTU;
         end
         if (mode == 2 && edges == 6) Signal = 6'd0;
         if (done) begin
            seen = 1;
            total++;
            if (edges !== lat) begin
               bad++;
               $display("FAIL %s latency: got %0d run edges, want %0d", tag, edges, lat);
            end
            total++;
            if ({HiOut, LoOut} !== full) begin
               bad++;
               $display("FAIL %s result: got %h_%h, want %h", tag, HiOut, LoOut, full);
            end
         end else begin
            total++;
            if (HiOut !== exp_hi || LoOut !== exp_lo || busy !== 1'b1) begin
               bad++;
               $display("FAIL %s running: got hi=%h lo=%h busy=%b, want hi=%h lo=%h busy=1",
                        tag, HiOut, LoOut, busy, exp_hi, exp_lo);
            end
         end
      end
      if (!seen) begin
         total++; bad++;
         $display("FAIL %s timeout: no done after %0d edges, want done at %0d", tag, edges, lat);
      end
      exp_hi = full[63:32];
      exp_lo = full[31:0];
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s after_done: got done=%b busy=%b, want 0 0", tag, done, busy);
      end
      if (mode != 0) begin
         pulses = 0;
         repeat (46) begin
            @(negedge clk);
            if (done || busy) pulses++;
         end
         total++;
         if (pulses !== 0 || {HiOut, LoOut} !== full) begin
            bad++;
            $display("FAIL %s no_restart: got %0d extra busy/done cycles hi=%h lo=%h, want 0 and %h",
                     tag, pulses, HiOut, LoOut, full);
         end
         Signal = 6'd0;
      end
   endtask

   task automatic test_directed();
      run_mul(32'd3, 32'd5, 0, "3x5");
      run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "max_x_max");
      run_mul(32'd9, 32'd4, 0, "9x4");
      run_mul(32'hDEAD_BEEF, 32'd0, 0, "b_zero");
      run_mul(32'd0, 32'h8000_0001, 0, "a_zero");
      run_mul(32'd1, 32'h8000_0000, 0, "b_msb");
   endtask

   task automatic test_hold();
      run_mul(32'd2, 32'd7, 1, "held_2x7");
   endtask

   task automatic test_mid_run();
      run_mul(32'h1234_5678, 32'h8765_4321, 2, "mid_run");
   endtask

   task automatic test_reset_abort();
      int spurious;
      @(negedge clk);
      dataA = 32'd12345; dataB = 32'd678; Signal = MULTU;
      @(posedge clk);
      #1 Signal = 6'd0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL abort_busy: got busy=%b, want 1", busy);
      end
      reset = 1'b1;
      #1;
      total++;
      if ({HiOut, LoOut, busy, done} !== 66'd0) begin
         bad++;
         $display("FAIL abort_async: got hi=%h lo=%h busy=%b done=%b, want all zero", HiOut, LoOut, busy, done);
      end
      exp_hi = '0; exp_lo = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      spurious = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy || HiOut != 0 || LoOut != 0) spurious++;
      end
      total++;
      if (spurious !== 0) begin
         bad++;
         $display("FAIL abort_quiet: got %0d cycles with activity, want 0", spurious);
      end
      run_mul(32'd12345, 32'd678, 0, "after_abort");
      total++;
      if (LoOut !== 32'd8369910) begin
         bad++;
         $display("FAIL after_abort_lo: got %0d, want 8369910", LoOut);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      for (int i = 0; i < 20; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         run_mul(a, b, 0, "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_mid_run();
      test_reset_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
